instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the RV32I instruction field decoder: accepts a decoded field bundle (opcode, rd, rs1, rs2, fn3, fn7_5, imm, imm_uj) and reassembles the 32-bit instruction word.
- Encoding round-trips bit-exactly through the decoder for every supported opcode.
- Streams words through a valid/ready pipeline and tags each with a byte address, so a testbench or boot loader can fill instruction memory.
- Illegal opcodes are dropped and counted.

Parameters:
- ADDR_W, 32, width of out_addr and base_addr.
- CNT_W, 8, width of illegal_cnt (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; reloads the address counter from base_addr.
- base_addr  in  ADDR_W  start byte address, sampled on start.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode  in  7  instruction[6:0].
- rd, rs1, rs2  in  5 each  register indices.
- fn3  in  3  funct3.
- fn7_5  in  1  funct7 bit 5 (R-type only).
- imm  in  12  I/load/store/JALR immediate, or B-type packed immediate.
- imm_uj  in  20  U-type upper immediate, or J-type packed immediate.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- illegal_cnt  out  CNT_W  number of dropped bundles, saturating.
- err  out  1  sticky; set on first illegal opcode.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_instr=0, out_addr=0.
  - Internal address counter=0, illegal_cnt=0, err=0.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !start & (!out_valid | out_ready).
  - One output register, latency 1 cycle, full throughput (one word per cycle with out_ready held high).
  - out_instr and out_addr hold stable while out_valid & !out_ready.
- Encoding on in_fire; word registered into out_instr. Unlisted bits are 0.
  - R (0110011): {1'b0, fn7_5, 5'b0, rs2, rs1, fn3, rd, opcode}.
  - I (0010011), load (0000011), JALR (1100111): {imm, rs1, fn3, rd, opcode}. Shift encodings come from imm[11:5].
  - Store (0100011): {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode}.
  - B (1100011): {imm[11], imm[9:4], rs2, rs1, fn3, imm[3:0], imm[10], opcode}. This mirrors the decoder's packing {i31, i7, i30:25, i11:8}.
  - JAL (1101111): {imm_uj[19], imm_uj[9:0], imm_uj[10], imm_uj[18:11], rd, opcode}.
  - LUI (0110111), AUIPC (0010111): {imm_uj, rd, opcode}.
- Illegal opcode (any other value) on in_fire:
  - Bundle consumed but not emitted.
  - out_valid is not set by it; address counter does not advance.
  - illegal_cnt increments, saturating at all-ones; err set (cleared only by reset).
- Address:
  - A legal in_fire loads out_addr <= counter, then counter += 4 (wraps modulo 2^ADDR_W).
  - start loads counter <= base_addr. in_ready is 0 in that cycle, so start and in_fire are never simultaneous.
  - A word already held in the output register keeps its out_addr across start.
- out_valid next state:
  - Set by a legal in_fire.
  - Cleared by out_fire without a legal in_fire.
  - out_fire and legal in_fire in the same cycle: the new word replaces the old, out_valid stays 1.
- Async reset mid-stream discards the pending word immediately; no partial outputs.

Test Plan:
- Reset, start with base_addr=0x100, send addi x1,x2,5 (op=0010011, rd=1, rs1=2, fn3=0, imm=0x005) -> out_instr=0x00510093, out_addr=0x100, next cycle.
- Back-to-back with out_ready=1:
  - sub x3,x1,x2 (fn7_5=1) -> 0x402081B3 @0x104.
  - sw x5,8(x2) (fn3=010, imm=0x008) -> 0x00512423 @0x108.
  - One word per cycle.
- beq x1,x2 with imm=0x004 -> 0x00208463; jal x1 with imm_uj=0x00004 -> 0x008000EF; lui x5 with imm_uj=0x12345 -> 0x123452B7.
- out_ready=0 for 3 cycles with in_valid held -> in_ready=0; out_instr/out_addr stable; no word lost or duplicated after release.
- opcode=0x7F between two legal words:
  - No output for it; illegal_cnt=1, err=1.
  - Legal words at consecutive addresses (0x100, 0x104).
  - 260 illegal bundles -> illegal_cnt saturates at 0xFF.
- start pulse with in_valid high -> in_ready=0 that cycle; next word gets out_addr=base_addr. Assert rst_n low mid-stream -> out_valid=0, err=0 asynchronously.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-bundle to instruction-word encoder with a single-entry valid/ready
// output stage, byte-address tagging and an illegal-opcode drop counter.
module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        fn3,
  input  logic              fn7_5,
  input  logic [11:0]       imm,
  input  logic [19:0]       imm_uj,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  illegal_cnt,
  output logic              err
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  ill_q, ill_d;
  logic              err_q, err_d;

  logic        in_fire, out_fire, legal;
  logic [31:0] word;

  assign in_ready = !start && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // B/J immediates arrive pre-packed in the decoder's field order, so only a
  // scatter is needed here, no re-shifting of the offset.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (opcode)
      OP_R:                     word = {1'b0, fn7_5, 5'b0, rs2, rs1, fn3, rd, opcode};
      OP_I, OP_LOAD, OP_JALR:   word = {imm, rs1, fn3, rd, opcode};
      OP_STORE:                 word = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
      OP_B:                     word = {imm[11], imm[9:4], rs2, rs1, fn3, imm[3:0], imm[10], opcode};
      OP_JAL:                   word = {imm_uj[19], imm_uj[9:0], imm_uj[10], imm_uj[18:11], rd, opcode};
      OP_LUI, OP_AUIPC:         word = {imm_uj, rd, opcode};
      default:                  legal = 1'b0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    cnt_d       = cnt_q;
    ill_d       = ill_q;
    err_d       = err_q;
    if (start) cnt_d = base_addr;
    if (in_fire && legal) begin
      out_valid_d = 1'b1;
      out_instr_d = word;
      out_addr_d  = cnt_q;
      cnt_d       = cnt_q + ADDR_W'(4);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (in_fire && !legal) begin
      if (ill_q != {CNT_W{1'b1}}) ill_d = ill_q + CNT_W'(1);
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      cnt_q       <= '0;
      ill_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      cnt_q       <= cnt_d;
      ill_q       <= ill_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = out_addr_q;
  assign illegal_cnt = ill_q;
  assign err         = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder, checked against a
// cycle-level reference model that builds words with field arithmetic.
module tb_instr_encoder;
  localparam int AW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0, out_ready = 1'b0, fn7_5 = 1'b0;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]    fn3 = '0;
  logic [11:0]   imm = '0;
  logic [19:0]   imm_uj = '0;
  logic          in_ready, out_valid, err;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic [CW-1:0] illegal_cnt;

  instr_encoder #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .fn3(fn3), .fn7_5(fn7_5), .imm(imm), .imm_uj(imm_uj),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .illegal_cnt(illegal_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // reference model state
  bit          mv;
  logic [31:0] mi, ma, mcnt;
  int          mill;
  bit          merr;

  logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] d, s1, s2,
                                      input logic [2:0] f3, input logic f7,
                                      input logic [11:0] im, input logic [19:0] uj);
    int unsigned OP = op, D = d, S1 = s1, S2 = s2, F3 = f3, F7 = f7, I = im, U = uj;
    int unsigned w = 0;
    case (op)
      7'h33: w = F7*(1<<30) + S2*(1<<20) + S1*(1<<15) + F3*(1<<12) + D*(1<<7) + OP;
      7'h13, 7'h03, 7'h67: w = I*(1<<20) + S1*(1<<15) + F3*(1<<12) + D*(1<<7) + OP;
      7'h23: w = (I/32)*(1<<25) + S2*(1<<20) + S1*(1<<15) + F3*(1<<12) + (I%32)*(1<<7) + OP;
      7'h63: w = (I/2048)*(32'h8000_0000) + ((I/16)%64)*(1<<25) + S2*(1<<20) + S1*(1<<15)
               + F3*(1<<12) + (I%16)*(1<<8) + ((I/1024)%2)*(1<<7) + OP;
      7'h6F: w = (U/(1<<19))*(32'h8000_0000) + (U%1024)*(1<<21) + ((U/1024)%2)*(1<<20)
               + ((U/2048)%256)*(1<<12) + D*(1<<7) + OP;
      7'h37, 7'h17: w = U*(1<<12) + D*(1<<7) + OP;
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_f(input logic [6:0] op, input logic [4:0] d, s1, s2, input logic [2:0] f3,
                       input logic f7, input logic [11:0] im, input logic [19:0] uj);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; fn3 = f3; fn7_5 = f7; imm = im; imm_uj = uj;
  endtask

  task automatic model_reset();
    mv = 0; mi = 0; ma = 0; mcnt = 0; mill = 0; merr = 0;
  endtask

  // One clock: check in_ready, advance model at the edge, check outputs after it.
  task automatic cyc();
    bit rdy, fire, lg;
    logic [31:0] e;
    #1;
    rdy  = !start && (!mv || out_ready);
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    fire = in_valid && rdy;
    lg   = is_legal(opcode);
    e    = enc(opcode, rd, rs1, rs2, fn3, fn7_5, imm, imm_uj);
    if (start) mcnt = base_addr;
    @(posedge clk);
    if (fire && lg) begin
      mi = e; ma = mcnt; mcnt = mcnt + 4; mv = 1;
    end else if (mv && out_ready) mv = 0;
    if (fire && !lg) begin
      if (mill < 255) mill++;
      merr = 1;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
    if (mv) begin
      chk("out_instr", out_instr, mi);
      chk("out_addr", out_addr, ma);
    end
    chk("illegal_cnt", 32'(illegal_cnt), mill);
    chk("err", {31'b0, err}, {31'b0, merr});
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // start with in_valid already high: nothing may be accepted that cycle
    out_ready = 1'b1;
    start = 1'b1; base_addr = 32'h100; in_valid = 1'b1;
    set_f(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 12'h005, 20'h0);
    #1 chk("start_in_ready", {31'b0, in_ready}, 32'd0);
    cyc();
    start = 1'b0;
    cyc();
    chk("addi_word", out_instr, 32'h00510093);
    chk("addi_addr", out_addr, 32'h100);
    set_f(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 12'h0, 20'h0);
    cyc();
    chk("sub_word", out_instr, 32'h402081B3);
    chk("sub_addr", out_addr, 32'h104);
    set_f(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 12'h008, 20'h0);
    cyc();
    chk("sw_word", out_instr, 32'h00512423);
    chk("sw_addr", out_addr, 32'h108);
    set_f(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 12'h004, 20'h0);
    cyc();
    chk("beq_word", out_instr, 32'h00208463);
    set_f(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 12'h0, 20'h00004);
    cyc();
    chk("jal_word", out_instr, 32'h008000EF);
    set_f(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 12'h0, 20'h12345);
    cyc();
    chk("lui_word", out_instr, 32'h123452B7);
    chk("lui_addr", out_addr, 32'h114);

    // backpressure: lui word must stay put, next bundle waits
    out_ready = 1'b0;
    set_f(7'h13, 5'd7, 5'd8, 5'd0, 3'd1, 1'b0, 12'h01F, 20'h0);
    for (int i = 0; i < 3; i++) cyc();
    chk("stall_hold_word", out_instr, 32'h123452B7);
    chk("stall_hold_addr", out_addr, 32'h114);
    out_ready = 1'b1;
    cyc();
    chk("stall_release_addr", out_addr, 32'h118);
    in_valid = 1'b0;
    cyc();

    // illegal bundle between two legal ones
    start = 1'b1; base_addr = 32'h100;
    cyc();
    start = 1'b0; in_valid = 1'b1;
    set_f(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 12'h005, 20'h0);
    cyc();
    chk("legal_a_addr", out_addr, 32'h100);
    set_f(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 12'h0, 20'h0);
    cyc();
    chk("illegal_no_out", {31'b0, out_valid}, 32'd0);
    chk("illegal_cnt_1", 32'(illegal_cnt), 32'd1);
    chk("illegal_err", {31'b0, err}, 32'd1);
    set_f(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 12'h0, 20'h0);
    cyc();
    chk("legal_b_addr", out_addr, 32'h104);
    set_f(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 12'h0, 20'h0);
    for (int i = 0; i < 260; i++) cyc();
    chk("illegal_sat", 32'(illegal_cnt), 32'hFF);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
      set_f(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom),
            12'($urandom), 20'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      start     = ($urandom_range(0, 29) == 0);
      base_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom} & 32'hFFFF_FFFC;
      cyc();
    end
    start = 1'b0;

    // make sure a word is pending, then pull reset between edges
    in_valid = 1'b1; out_ready = 1'b0;
    set_f(7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0, 12'h0, 20'hABCDE);
    cyc();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_err", {31'b0, err}, 32'd0);
    chk("async_rst_cnt", 32'(illegal_cnt), 32'd0);
    chk("async_rst_addr", out_addr, 32'd0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
